// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a req/gnt/rvalid data bus: byte lanes, store replication, load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise misalign_err.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_EXMEM_out,
  input  logic              memRead_EXMEM_out,
  input  logic              memWrite_EXMEM_out,
  input  logic [1:0]        size_EXMEM_out,
  input  logic              unsigned_EXMEM_out,
  input  logic [ADDR_W-1:0] execute_result_EXMEM_out,
  input  logic [31:0]       store_data_EXMEM_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       memReadRst,
  output logic              mem_stall,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic        start;
  logic        misaligned;
  logic        load_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign start = valid_EXMEM_out & (memRead_EXMEM_out | memWrite_EXMEM_out);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (size_EXMEM_out == 2'b01)
      misaligned = execute_result_EXMEM_out[0];
    else if (size_EXMEM_out[1])
      misaligned = (execute_result_EXMEM_out[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else
      misalign_err <= (state == IDLE) && start && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Lane offset ignores the low address bits a half/word cannot use, so untrapped misaligned accesses act aligned.
  always_comb begin
    off_in   = 2'b00;
    be_in    = 4'b1111;
    wdata_in = store_data_EXMEM_out;
    case (size_EXMEM_out)
      2'b00: begin
        off_in   = execute_result_EXMEM_out[1:0];
        be_in    = 4'b0001 << execute_result_EXMEM_out[1:0];
        wdata_in = {4{store_data_EXMEM_out[7:0]}};
      end
      2'b01: begin
        off_in   = {execute_result_EXMEM_out[1], 1'b0};
        be_in    = execute_result_EXMEM_out[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data_EXMEM_out[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: if (start) begin
        mem_stall  = 1'b1;
        state_next = misaligned ? DONE : REQ;
      end
      REQ: begin
        mem_stall = 1'b1;
        if (mem_gnt) state_next = load_q ? WAIT : DONE;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (mem_rvalid) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_req = (state == REQ);
  assign mem_we  = (state == REQ) & ~load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      memReadRst <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start && !misaligned) begin
        load_q    <= memRead_EXMEM_out;
        uns_q     <= unsigned_EXMEM_out;
        size_q    <= size_EXMEM_out;
        off_q     <= off_in;
        mem_addr  <= {execute_result_EXMEM_out[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata_in;
        mem_be    <= be_in;
      end
      if (state == WAIT && mem_rvalid)
        memReadRst <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of complete accesses plus reset and misalign sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, uns = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, sdata = '0;
  logic        mem_req, mem_we, mem_stall, misalign_err;
  logic [31:0] mem_addr, mem_wdata, memReadRst;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_EXMEM_out(valid), .memRead_EXMEM_out(mem_read), .memWrite_EXMEM_out(mem_write),
    .size_EXMEM_out(size), .unsigned_EXMEM_out(uns),
    .execute_result_EXMEM_out(addr), .store_data_EXMEM_out(sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .memReadRst(memReadRst), .mem_stall(mem_stall), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, sdata, rdata;
    int unsigned gnt_dly;
    logic [3:0]  be;
    logic [31:0] wdata, bus_addr, result;
    int unsigned stalls;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, " mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, " mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " memReadRst"}, memReadRst, 32'd0);
    check({tag, " misalign_err"}, {31'b0, misalign_err}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int stall_cnt = 0;
    logic exp_we = v.wr & ~v.rd;
    @(posedge clk); #1;
    valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
    size = v.size; uns = v.uns; addr = v.addr; sdata = v.sdata;
    @(negedge clk);
    if (mem_stall) stall_cnt++;
    check({tag, " idle_req"}, {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    for (int unsigned g = 0; g <= v.gnt_dly; g++) begin
      mem_gnt = (g == v.gnt_dly);
      @(negedge clk);
      if (mem_stall) stall_cnt++;
      check($sformatf("%s req[%0d]", tag, g), {31'b0, mem_req}, 32'd1);
      check($sformatf("%s we[%0d]", tag, g), {31'b0, mem_we}, {31'b0, exp_we});
      check($sformatf("%s addr[%0d]", tag, g), mem_addr, v.bus_addr);
      check($sformatf("%s be[%0d]", tag, g), {28'b0, mem_be}, {28'b0, v.be});
      check($sformatf("%s wdata[%0d]", tag, g), mem_wdata, v.wdata);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
    end
    if (v.rd) begin
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      if (mem_stall) stall_cnt++;
      check({tag, " wait_req"}, {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    end
    // DONE: keep start asserted to show it does not launch another access
    @(negedge clk);
    if (mem_stall) stall_cnt++;
    check({tag, " done_result"}, memReadRst, v.result);
    check({tag, " done_misalign"}, {31'b0, misalign_err}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({tag, " after_done_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, " stall_cycles"}, stall_cnt, v.stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1,0,2'b00,1,32'h103,32'h0,32'h80FF_1234,0,4'b1000,32'h0,32'h100,32'h0000_0080,3};
    vecs[1] = '{1,0,2'b01,0,32'h102,32'h0,32'h80FF_1234,0,4'b1100,32'h0,32'h100,32'hFFFF_80FF,3};
    vecs[2] = '{0,1,2'b00,0,32'h201,32'h1234_56AB,32'h0,3,4'b0010,32'hABAB_ABAB,32'h200,32'hFFFF_80FF,5};
    vecs[3] = '{1,1,2'b10,0,32'h40,32'h1111_2222,32'hDEAD_BEEF,0,4'b1111,32'h1111_2222,32'h40,32'hDEAD_BEEF,3};
    vecs[4] = '{0,1,2'b01,0,32'h0E,32'h0000_BEEF,32'h0,0,4'b1100,32'hBEEF_BEEF,32'h0C,32'hDEAD_BEEF,2};
    vecs[5] = '{1,0,2'b00,0,32'h01,32'h0,32'h0000_8000,1,4'b0010,32'h0,32'h0,32'hFFFF_FF80,4};
    vecs[6] = '{1,0,2'b01,1,32'h00,32'h0,32'h1234_F00D,0,4'b0011,32'h0,32'h0,32'h0000_F00D,3};
    vecs[7] = '{0,1,2'b11,0,32'h80,32'hCAFE_F00D,32'h0,0,4'b1111,32'hCAFE_F00D,32'h80,32'h0000_F00D,2};
    vecs[8] = '{1,0,2'b10,0,32'h04,32'h0,32'h8765_4321,2,4'b1111,32'h0,32'h04,32'h8765_4321,5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h102;
    @(negedge clk);
    check("trap idle_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("trap req", {31'b0, mem_req}, 32'd0);
    check("trap err", {31'b0, misalign_err}, 32'd1);
    check("trap done_stall", {31'b0, mem_stall}, 32'd0);
    check("trap result", memReadRst, 32'h8765_4321);
    @(posedge clk); #1;
    @(negedge clk);
    check("trap err_clear", {31'b0, misalign_err}, 32'd0);
    check("trap req_after", {31'b0, mem_req}, 32'd0);
`else
    run_vec('{1,0,2'b10,0,32'h102,32'h0,32'h1122_3344,0,4'b1111,32'h0,32'h100,32'h1122_3344,3}, "misalign_word");
`endif

    // Reset while waiting for load data; the late rvalid must be dropped.
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h10; sdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rst_mid wait_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rst_mid late_rvalid result", memReadRst, 32'd0);
    check("rst_mid late_rvalid req", {31'b0, mem_req}, 32'd0);
    check("rst_mid late_rvalid stall", {31'b0, mem_stall}, 32'd0);

    run_vec(vecs[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
